fifo_wr_gen: RTL and testbench
==============================

Name: fifo_wr_gen

Overview:
Write-side traffic generator for the FIFO loopback test. It writes a burst of BURST_LEN 16-bit incrementing words (PAT_BASE, PAT_BASE+1, ...) into the FIFO write port and obeys the FIFO's reset-busy and fill flags. It is the producer for the read-side checker, which expects exactly this sequence. It runs entirely in the FIFO write clock domain.

Parameters:
BURST_LEN, 1536, number of words written per start; legal range 1..65535.
PAT_BASE, 16'd0, value of the first word of every burst.
INIT_WAIT, 10, write-clock cycles to wait after wr_rst_busy deasserts before the first write.

Ports:
wr_clk  input  1  FIFO write clock; the only clock.
rst  input  1  reset; synchronous, active-high.
start  input  1  single-cycle pulse; launches one burst when idle.
wr_rst_busy  input  1  FIFO write-side reset in progress.
full  input  1  FIFO full.
almost_full  input  1  FIFO has one free slot or none.
prog_full  input  1  programmable-full threshold reached.
fifo_wr_en  output  1  FIFO write enable.
fifo_wr_data  output  16  FIFO write data; valid when fifo_wr_en=1.
busy  output  1  high from the start acceptance up to and including the done pulse.
done  output  1  single-cycle pulse after the last word of a burst is written.
wr_cnt  output  16  words written in the current or most recent burst.

Behaviour:
- Reset values: fifo_wr_en=0, fifo_wr_data=PAT_BASE, busy=0, done=0, wr_cnt=0, state=IDLE, init counter=0.
- State machine states: IDLE, INIT, WRITE, PAUSE, DONE.
- IDLE: on start=1, go to INIT, load fifo_wr_data=PAT_BASE, clear wr_cnt, set busy=1.
- INIT: the init counter counts only while wr_rst_busy=0. If wr_rst_busy=1, the counter clears. After INIT_WAIT consecutive cycles with wr_rst_busy=0, go to WRITE.
- Write enable rule: fifo_wr_en = (state==WRITE) & ~full & ~almost_full & ~prog_full & ~wr_rst_busy. It is combinational from registered state, so a write decision has zero latency.
- The slot signalled by almost_full is intentionally left unused. This prevents overflow.
- Each cycle with fifo_wr_en=1: fifo_wr_data increments by 1 (modulo 2^16, so 16'hFFFF wraps to 0) and wr_cnt increments by 1.
- WRITE: go to PAUSE when prog_full=1 or almost_full=1. Go to DONE in the same cycle that the word completing the burst is written (wr_cnt==BURST_LEN-1 with fifo_wr_en=1).
- PAUSE: return to WRITE when prog_full=0 and almost_full=0. No writes are issued in PAUSE.
- If wr_rst_busy rises in WRITE or PAUSE, go to INIT. wr_cnt and fifo_wr_data are kept, so the burst resumes where it stopped.
- DONE: done=1 for one cycle, busy drops in the next cycle, then go to IDLE.
- start is ignored whenever state!=IDLE. There is no queuing.
- start in the same cycle as rst: rst wins.
- rst asserted mid-burst: everything returns to reset values in the next cycle. No partial-word write can occur after rst is sampled.
- full=1 is never expected while fifo_wr_en could assert. It is gated anyway as a safety net.
- wr_cnt holds its final value (BURST_LEN) after done until the next start.

Decomposition:
- Shared package fifo_test_pkg holds: the state enum (IDLE/INIT/WRITE/PAUSE/DONE), DATA_W=16, the default burst length 1536, and the default PAT_BASE. The read checker uses the same burst length and PAT_BASE constants.
- One natural sub-module, fifo_init_wait: a counter that asserts ready after INIT_WAIT clean cycles of wr_rst_busy=0 and clears when wr_rst_busy asserts.
- All other logic stays in fifo_wr_gen.

Test Plan:
- Basic burst: rst released, wr_rst_busy=0, start pulse, FIFO never fills -> first write 11 cycles after start (1 cycle into INIT plus INIT_WAIT=10). Data 0..1535 on 1536 consecutive fifo_wr_en cycles. done pulses once. wr_cnt=1536. busy low afterwards.
- Backpressure: prog_full forced high after word 700 for 50 cycles -> last data before the stall is 699 and no write occurs for 50 cycles. Resume with 700, no gap or duplicate in the sequence. Total is still 1536.
- Reset-busy interlock: wr_rst_busy high for 20 cycles after start -> no write until 10 cycles after it falls. wr_rst_busy pulsed mid-burst at word 300 -> writes halt, then resume at 300 after INIT_WAIT.
- Overflow guard: almost_full tied to a 1024-deep FIFO model with no reader -> fifo_wr_en never asserts while almost_full=1. FIFO full flag never coincides with fifo_wr_en. Generator sits in PAUSE.
- Start/reset corners: start asserted again mid-burst is ignored (exactly 1536 words). rst asserted at word 900 -> outputs return to reset values the next cycle. A new start then restarts at data 0 with wr_cnt 0.
- Wrap: PAT_BASE=16'hFFFE, BURST_LEN=4 -> data FFFE, FFFF, 0000, 0001, then done.

Source files
------------

// File: rtl/fifo_test_pkg.sv
// Constants and types shared by the FIFO loopback write generator and read checker.
// Both sides must agree on burst length and pattern base or the checker will flag errors.
package fifo_test_pkg;

   localparam int unsigned DATA_W        = 16;
   localparam int unsigned DEF_BURST_LEN = 1536;
   localparam logic [DATA_W-1:0] DEF_PAT_BASE = 16'd0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      WRITE = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } wr_state_e;

   // Next pattern word; wraps modulo 2^DATA_W.
   function automatic logic [DATA_W-1:0] inc_word(input logic [DATA_W-1:0] w);
      return w + DATA_W'(1);
   endfunction

endpackage

// File: rtl/fifo_wr_gen_if.sv
// FIFO write-port bundle: enable/data towards the FIFO, reset-busy and fill flags back.
// master = traffic generator, slave = FIFO write side.
interface fifo_wr_gen_if;
   import fifo_test_pkg::*;

   logic              fifo_wr_en;
   logic [DATA_W-1:0] fifo_wr_data;
   logic              wr_rst_busy;
   logic              full;
   logic              almost_full;
   logic              prog_full;

   modport master (
      output fifo_wr_en,
      output fifo_wr_data,
      input  wr_rst_busy,
      input  full,
      input  almost_full,
      input  prog_full
   );

   modport slave (
      input  fifo_wr_en,
      input  fifo_wr_data,
      output wr_rst_busy,
      output full,
      output almost_full,
      output prog_full
   );

endinterface

// File: rtl/fifo_init_wait.sv
// Settling counter: ready_o is high once INIT_WAIT consecutive enabled cycles have seen
// wr_rst_busy low; any busy cycle or leaving the enabled state restarts the count.
module fifo_init_wait #(
   parameter int unsigned INIT_WAIT = 10
) (
   input  logic wr_clk,
   input  logic rst,
   input  logic en_i,
   input  logic wr_rst_busy_i,
   output logic ready_o
);

   localparam int unsigned CW = $clog2(INIT_WAIT + 2);
   localparam logic [CW-1:0] LAST = CW'((INIT_WAIT > 0) ? INIT_WAIT - 1 : 0);

   logic [CW-1:0] cnt_q;

   assign ready_o = en_i & ~wr_rst_busy_i & (cnt_q >= LAST);

   always_ff @(posedge wr_clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (!en_i || wr_rst_busy_i || ready_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/fifo_wr_gen.sv
// Writes BURST_LEN incrementing words per start into a FIFO; write decision is zero-latency
// from registered state, and almost_full/prog_full/full/wr_rst_busy all block writes at once.
module fifo_wr_gen
   import fifo_test_pkg::*;
#(
   parameter int unsigned       BURST_LEN = DEF_BURST_LEN,
   parameter logic [DATA_W-1:0] PAT_BASE  = DEF_PAT_BASE,
   parameter int unsigned       INIT_WAIT = 10
) (
   input  logic              wr_clk,
   input  logic              rst,
   input  logic              start,
   fifo_wr_gen_if.master     fifo,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] wr_cnt
);

   localparam logic [DATA_W-1:0] LAST_CNT = DATA_W'(BURST_LEN - 1);

   wr_state_e         state_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] cnt_q;
   logic              busy_q;
   logic              done_q;
   logic              wr_en;
   logic              fill_stop;
   logic              init_ready;

   // The almost_full slot is deliberately left unused so the FIFO can never overflow.
   assign fill_stop = fifo.almost_full | fifo.prog_full;
   assign wr_en     = (state_q == WRITE) & ~fifo.full & ~fill_stop & ~fifo.wr_rst_busy;

   assign fifo.fifo_wr_en   = wr_en;
   assign fifo.fifo_wr_data = data_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign wr_cnt            = cnt_q;

   fifo_init_wait #(
      .INIT_WAIT (INIT_WAIT)
   ) u_init_wait (
      .wr_clk        (wr_clk),
      .rst           (rst),
      .en_i          (state_q == INIT),
      .wr_rst_busy_i (fifo.wr_rst_busy),
      .ready_o       (init_ready)
   );

   always_ff @(posedge wr_clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= PAT_BASE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         if (wr_en) begin
            data_q <= inc_word(data_q);
            cnt_q  <= cnt_q + DATA_W'(1);
         end

         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= INIT;
                  data_q  <= PAT_BASE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            INIT: begin
               if (init_ready) begin
                  state_q <= WRITE;
               end
            end
            WRITE: begin
               // Data and count are kept across a FIFO reset so the burst resumes in place.
               if (fifo.wr_rst_busy) begin
                  state_q <= INIT;
               end else if (wr_en && (cnt_q == LAST_CNT)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else if (fill_stop) begin
                  state_q <= PAUSE;
               end
            end
            PAUSE: begin
               if (fifo.wr_rst_busy) begin
                  state_q <= INIT;
               end else if (!fill_stop) begin
                  state_q <= WRITE;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_gen.sv
// Directed and randomized bench for fifo_wr_gen: writes are captured into a queue and
// compared against the ideal incrementing sequence, with a FIFO occupancy model for flags.
module tb_fifo_wr_gen;

   logic        clk;
   logic        rst;
   logic        start;
   logic        busy;
   logic        done;
   logic [15:0] wr_cnt;
   logic        start2;
   logic        busy2;
   logic        done2;
   logic [15:0] wr_cnt2;

   fifo_wr_gen_if bus ();
   fifo_wr_gen_if bus2 ();

   fifo_wr_gen #(
      .BURST_LEN (1536),
      .PAT_BASE  (16'h0000),
      .INIT_WAIT (10)
   ) dut (
      .wr_clk (clk),
      .rst    (rst),
      .start  (start),
      .fifo   (bus),
      .busy   (busy),
      .done   (done),
      .wr_cnt (wr_cnt)
   );

   fifo_wr_gen #(
      .BURST_LEN (4),
      .PAT_BASE  (16'hFFFE),
      .INIT_WAIT (10)
   ) dut_wrap (
      .wr_clk (clk),
      .rst    (rst),
      .start  (start2),
      .fifo   (bus2),
      .busy   (busy2),
      .done   (done2),
      .wr_cnt (wr_cnt2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          cyc;
   int          n_checks;
   int          n_pass;
   int          n_fail;
   int          n_wr;
   int          n_rd;
   int          n_done;
   int          n_done2;
   int          viol;
   int          start_cyc;
   bit          ovf_mode;
   bit          drain;
   logic [15:0] got[$];
   logic [15:0] got2[$];
   int          wcyc[$];

   always @(posedge clk) cyc++;

   // Writes are sampled mid-cycle; the FIFO accepts them on the following rising edge.
   always @(negedge clk) begin
      if (bus.fifo_wr_en) begin
         got.push_back(bus.fifo_wr_data);
         wcyc.push_back(cyc);
         n_wr++;
      end
      if (bus.fifo_wr_en && (bus.full || bus.almost_full || bus.prog_full || bus.wr_rst_busy))
         viol++;
      if (done) n_done++;
      if (bus2.fifo_wr_en) got2.push_back(bus2.fifo_wr_data);
      if (done2) n_done2++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // 1024-deep FIFO model: flags follow occupancy after each write edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (ovf_mode) begin
         if (drain) n_rd = n_wr;
         bus.full        = (n_wr - n_rd) >= 1024;
         bus.almost_full = (n_wr - n_rd) >= 1023;
         bus.prog_full   = 1'b0;
      end
   endtask

   task automatic clear_counts();
      got.delete();
      got2.delete();
      wcyc.delete();
      n_wr = 0;
      n_rd = 0;
      n_done = 0;
      n_done2 = 0;
      viol = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      start_cyc = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         tick();
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic wait_wr(input string tag, input int n, input int budget);
      bit seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         tick();
         if (n_wr >= n) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_wr_reached"}, 32'(seen), 32'd1);
   endtask

   function automatic int seq_bad(input logic [15:0] q[$], input logic [15:0] base, input int n);
      logic [15:0] e;
      e = base;
      if (q.size() != n) return -2;
      foreach (q[i]) begin
         if (q[i] !== e) return i;
         e = e + 16'd1;
      end
      return -1;
   endfunction

   initial begin
      int pf_left;
      int rb_left;
      bit seen;
      cyc = 0;
      n_checks = 0;
      n_pass = 0;
      n_fail = 0;
      ovf_mode = 1'b0;
      drain = 1'b0;
      rst = 1'b1;
      start = 1'b0;
      start2 = 1'b0;
      bus.wr_rst_busy = 1'b0;
      bus.full = 1'b0;
      bus.almost_full = 1'b0;
      bus.prog_full = 1'b0;
      bus2.wr_rst_busy = 1'b0;
      bus2.full = 1'b0;
      bus2.almost_full = 1'b0;
      bus2.prog_full = 1'b0;
      clear_counts();
      repeat (3) tick();

      check("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      check("rst_data", 32'(bus.fifo_wr_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
      check("rst_wrap_data", 32'(bus2.fifo_wr_data), 32'hFFFE);
      rst = 1'b0;
      repeat (2) tick();

      // Basic burst
      clear_counts();
      pulse_start();
      check("basic_busy_on", 32'(busy), 32'd1);
      wait_done("basic", 3000);
      check("basic_busy_in_done", 32'(busy), 32'd1);
      check("basic_latency", 32'(wcyc[0] - start_cyc), 32'd11);
      check("basic_seq", 32'(seq_bad(got, 16'h0000, 1536)), 32'hFFFF_FFFF);
      check("basic_contig", 32'(wcyc[wcyc.size()-1] - wcyc[0]), 32'd1535);
      check("basic_wr_cnt", 32'(wr_cnt), 32'd1536);
      tick();
      check("basic_busy_off", 32'(busy), 32'd0);
      check("basic_done_once", 32'(n_done), 32'd1);
      repeat (3) tick();
      check("basic_wr_cnt_hold", 32'(wr_cnt), 32'd1536);

      // Backpressure via prog_full after word 700
      clear_counts();
      pulse_start();
      wait_wr("bp", 700, 3000);
      bus.prog_full = 1'b1;
      repeat (50) tick();
      check("bp_stalled", 32'(n_wr), 32'd700);
      check("bp_last_before", 32'(got[699]), 32'd699);
      bus.prog_full = 1'b0;
      wait_done("bp", 3000);
      check("bp_seq", 32'(seq_bad(got, 16'h0000, 1536)), 32'hFFFF_FFFF);
      check("bp_gap", 32'(wcyc[700] - wcyc[699]), 32'd52);
      tick();

      // Reset-busy interlock at start and mid-burst
      clear_counts();
      bus.wr_rst_busy = 1'b1;
      pulse_start();
      repeat (19) tick();
      bus.wr_rst_busy = 1'b0;
      wait_wr("rb", 300, 3000);
      check("rb_latency", 32'(wcyc[0] - start_cyc), 32'd30);
      bus.wr_rst_busy = 1'b1;
      repeat (5) tick();
      check("rb_halted", 32'(n_wr), 32'd300);
      bus.wr_rst_busy = 1'b0;
      wait_done("rb", 3000);
      check("rb_gap", 32'(wcyc[300] - wcyc[299]), 32'd16);
      check("rb_seq", 32'(seq_bad(got, 16'h0000, 1536)), 32'hFFFF_FFFF);
      tick();

      // Overflow guard against a 1024-deep FIFO with no reader
      clear_counts();
      ovf_mode = 1'b1;
      drain = 1'b0;
      pulse_start();
      repeat (1200) tick();
      check("ovf_writes", 32'(n_wr), 32'd1023);
      check("ovf_wr_cnt", 32'(wr_cnt), 32'd1023);
      check("ovf_busy", 32'(busy), 32'd1);
      check("ovf_viol", 32'(viol), 32'd0);
      drain = 1'b1;
      wait_done("ovf", 3000);
      check("ovf_seq", 32'(seq_bad(got, 16'h0000, 1536)), 32'hFFFF_FFFF);
      check("ovf_viol_end", 32'(viol), 32'd0);
      ovf_mode = 1'b0;
      drain = 1'b0;
      bus.full = 1'b0;
      bus.almost_full = 1'b0;
      tick();

      // Second start mid-burst is ignored
      clear_counts();
      pulse_start();
      wait_wr("restart", 100, 3000);
      pulse_start();
      wait_done("restart", 3000);
      tick();
      check("restart_count", 32'(n_wr), 32'd1536);
      check("restart_done_once", 32'(n_done), 32'd1);

      // Reset mid-burst at word 900
      clear_counts();
      pulse_start();
      wait_wr("midrst", 900, 3000);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      check("midrst_data", 32'(bus.fifo_wr_data), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_wr_cnt", 32'(wr_cnt), 32'd0);

      // start coincident with rst is dropped
      clear_counts();
      rst = 1'b1;
      start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      repeat (20) tick();
      check("rst_start_busy", 32'(busy), 32'd0);
      check("rst_start_nowr", 32'(n_wr), 32'd0);

      // Fresh burst after reset restarts from the pattern base
      clear_counts();
      pulse_start();
      wait_done("post_rst", 3000);
      check("post_rst_latency", 32'(wcyc[0] - start_cyc), 32'd11);
      check("post_rst_seq", 32'(seq_bad(got, 16'h0000, 1536)), 32'hFFFF_FFFF);
      tick();

      // Pattern wrap on the short-burst instance
      clear_counts();
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (done2) begin
            seen = 1'b1;
            break;
         end
      end
      check("wrap_done_seen", 32'(seen), 32'd1);
      check("wrap_seq", 32'(seq_bad(got2, 16'hFFFE, 4)), 32'hFFFF_FFFF);
      check("wrap_wr_cnt", 32'(wr_cnt2), 32'd4);
      tick();
      check("wrap_done_once", 32'(n_done2), 32'd1);

      // Randomized prog_full / almost_full / wr_rst_busy disturbance
      clear_counts();
      pf_left = 0;
      rb_left = 0;
      pulse_start();
      seen = 1'b0;
      for (int k = 0; k < 30000; k++) begin
         if (pf_left > 0) pf_left--;
         else if ($urandom_range(0, 15) == 0) pf_left = $urandom_range(1, 12);
         if (rb_left > 0) rb_left--;
         else if ($urandom_range(0, 299) == 0) rb_left = $urandom_range(1, 6);
         bus.prog_full   = (pf_left > 0);
         bus.almost_full = (pf_left > 0) && ($urandom_range(0, 1) == 1);
         bus.wr_rst_busy = (rb_left > 0);
         tick();
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      bus.prog_full = 1'b0;
      bus.almost_full = 1'b0;
      bus.wr_rst_busy = 1'b0;
      check("rand_done_seen", 32'(seen), 32'd1);
      check("rand_seq", 32'(seq_bad(got, 16'h0000, 1536)), 32'hFFFF_FFFF);
      check("rand_viol", 32'(viol), 32'd0);
      check("rand_wr_cnt", 32'(wr_cnt), 32'd1536);
      tick();
      check("rand_done_once", 32'(n_done), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
